// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared mode encodings, segment constants and BCD-to-7-segment lookup
package stopwatch_pkg;
  localparam logic [1:0] MODE_LIVE     = 2'd0;
  localparam logic [1:0] MODE_REC_HOLD = 2'd1;
  localparam logic [1:0] MODE_REC_VIEW = 2'd2;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  // Active-low {g,f,e,d,c,b,a}; non-BCD nibbles show a dash
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return SEG_DASH;
    endcase
  endfunction
endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync: 2-FF synchronizer on an active-low button plus registered falling-edge pulse
module btn_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_fall
);
  logic [2:0] r_sync;
  logic       r_fall;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '1;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], i_btn_n};
      r_fall <= r_sync[2] & ~r_sync[1];
    end
  end
  assign o_fall = r_fall;
endmodule

// File: rtl/stopwatch_display.sv
// stopwatch_display: selects live or lap time and scan-multiplexes it onto a 4-digit 7-segment display
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int HOLD_FRAMES = 200
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] iCurTime,
  input  logic [15:0] iRecTime,
  input  logic        iRecValid,
  input  logic        fView,
  output logic [6:0]  oSeg,
  output logic        oDp,
  output logic [3:0]  oDigit,
  output logic [1:0]  oMode
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_frame;
  logic [HW-1:0] r_hold;
  logic [1:0]    r_mode;
  logic          r_first;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_digit;
  logic          w_view_evt;
  logic          w_wrap;
  logic          w_frame_end;
  logic [15:0]   w_src;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg;
  logic [1:0]    w_mode_nxt;
  logic [HW-1:0] w_hold_nxt;

  btn_edge_sync u_view (
    .i_clk   (Clk),
    .i_rst_n (Rst),
    .i_btn_n (fView),
    .o_fall  (w_view_evt)
  );

  assign w_wrap      = r_cnt == CW'(REFRESH_DIV - 1);
  assign w_frame_end = w_wrap && r_idx == 2'd3;
  assign w_src       = r_mode == MODE_LIVE ? iCurTime : iRecTime;
  assign w_nib       = r_frame[{r_idx, 2'b00} +: 4];
  // Only the leftmost digit is leading-zero blanked
  assign w_seg       = (r_idx == 2'd3 && w_nib == 4'h0) ? SEG_BLANK : bcd_to_seg(w_nib);

  always_comb begin
    w_mode_nxt = r_mode;
    w_hold_nxt = r_hold;
    if (r_mode == MODE_REC_VIEW)
      w_mode_nxt = w_view_evt ? MODE_LIVE : r_mode;
    else if (w_view_evt)
      w_mode_nxt = MODE_REC_VIEW;
    else if (iRecValid) begin
      w_mode_nxt = MODE_REC_HOLD;
      w_hold_nxt = HW'(HOLD_FRAMES);
    end else if (r_mode == MODE_REC_HOLD && w_frame_end) begin
      w_hold_nxt = r_hold - 1'b1;
      w_mode_nxt = r_hold == HW'(1) ? MODE_LIVE : r_mode;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_frame <= 16'h0000;
      r_hold  <= '0;
      r_mode  <= MODE_LIVE;
      r_first <= 1'b1;
      r_seg   <= SEG_BLANK;
      r_dp    <= 1'b1;
      r_digit <= 4'hF;
    end else begin
      r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
      r_idx   <= w_wrap ? r_idx + 2'd1 : r_idx;
      r_first <= 1'b0;
      // Frame only reloads between scans so a digit set never mixes two times
      r_frame <= (r_first || w_frame_end) ? w_src : r_frame;
      r_hold  <= w_hold_nxt;
      r_mode  <= w_mode_nxt;
      r_seg   <= w_seg;
      r_dp    <= r_idx != 2'd2;
      r_digit <= ~(4'b0001 << r_idx);
    end
  end

  assign oSeg   = r_seg;
  assign oDp    = r_dp;
  assign oDigit = r_digit;
  assign oMode  = r_mode;
endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display: directed self-checking bench for stopwatch_display (REFRESH_DIV=4, HOLD_FRAMES=2)
module tb_stopwatch_display;
  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] iCurTime;
  logic [15:0] iRecTime;
  logic        iRecValid;
  logic        fView;
  logic [6:0]  oSeg;
  logic        oDp;
  logic [3:0]  oDigit;
  logic [1:0]  oMode;
  int checks = 0;
  int errors = 0;

  stopwatch_display #(.REFRESH_DIV(4), .HOLD_FRAMES(2)) dut (
    .Clk(Clk), .Rst(Rst), .iCurTime(iCurTime), .iRecTime(iRecTime), .iRecValid(iRecValid),
    .fView(fView), .oSeg(oSeg), .oDp(oDp), .oDigit(oDigit), .oMode(oMode)
  );

  always #10 Clk = ~Clk;

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [3:0] dig_exp [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] t2_seg  [8] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h00, 7'h78, 7'h02, 7'h12};
  logic [6:0] t3_seg  [4] = '{7'h24, 7'h19, 7'h10, 7'h7F};

  initial begin
    Rst = 1'b0; fView = 1'b1; iCurTime = 16'h0000; iRecTime = 16'h0000; iRecValid = 1'b0;
    tick(2);
    chk("rst_seg", 16'(oSeg), 16'h7F);
    chk("rst_dp", 16'(oDp), 16'h1);
    chk("rst_digit", 16'(oDigit), 16'hF);
    chk("rst_mode", 16'(oMode), 16'h0);
    Rst = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick(4);
      chk("t1_digit", 16'(oDigit), 16'(dig_exp[i]));
      chk("t1_seg", 16'(oSeg), i == 3 ? 16'h7F : 16'h40);
      chk("t1_dp", 16'(oDp), i == 2 ? 16'h0 : 16'h1);
    end
    chk("t1_mode", 16'(oMode), 16'h0);
    iCurTime = 16'h1234;
    for (int i = 0; i < 8; i++) begin
      tick(4);
      chk("t2_digit", 16'(oDigit), 16'(dig_exp[i % 4]));
      chk("t2_seg", 16'(oSeg), 16'(t2_seg[i]));
      if (i == 1) iCurTime = 16'h5678;
    end
    iRecTime = 16'h0942; iRecValid = 1'b1;
    tick(1);
    iRecValid = 1'b0;
    chk("t3_mode_hold", 16'(oMode), 16'h1);
    tick(3);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick(4);
      chk("t3_seg", 16'(oSeg), 16'(t3_seg[i]));
    end
    chk("t3_mode_still_hold", 16'(oMode), 16'h1);
    tick(3);
    chk("t3_mode_live", 16'(oMode), 16'h0);
    tick(1);
    chk("t3_rec_lingers", 16'(oSeg), 16'h24);
    tick(16);
    chk("t3_live_back", 16'(oSeg), 16'h00);
    fView = 1'b0;
    tick(3);
    chk("t4_mode_before", 16'(oMode), 16'h0);
    tick(1);
    chk("t4_mode_view", 16'(oMode), 16'h2);
    tick(6);
    fView = 1'b1; iRecValid = 1'b1;
    tick(1);
    iRecValid = 1'b0;
    chk("t4_rec_ignored", 16'(oMode), 16'h2);
    tick(1);
    fView = 1'b0;
    tick(4);
    chk("t4_mode_back_live", 16'(oMode), 16'h0);
    fView = 1'b1;
    tick(3);
    fView = 1'b0;
    tick(3);
    iRecValid = 1'b1; iRecTime = 16'h0A00;
    tick(1);
    iRecValid = 1'b0; fView = 1'b1;
    chk("t5_view_wins", 16'(oMode), 16'h2);
    tick(17);
    chk("t5_dash_digit", 16'(oDigit), 16'hB);
    chk("t5_dash_seg", 16'(oSeg), 16'h3F);
    chk("t5_dash_dp", 16'(oDp), 16'h0);
    #4;
    Rst = 1'b0;
    #1;
    chk("t6_async_seg", 16'(oSeg), 16'h7F);
    chk("t6_async_dp", 16'(oDp), 16'h1);
    chk("t6_async_digit", 16'(oDigit), 16'hF);
    chk("t6_async_mode", 16'(oMode), 16'h0);
    Rst = 1'b1;
    tick(1);
    chk("t6_restart_digit", 16'(oDigit), 16'hE);
    chk("t6_restart_seg", 16'(oSeg), 16'h40);
    tick(4);
    chk("t6_digit1", 16'(oDigit), 16'hD);
    chk("t6_seg1", 16'(oSeg), 16'h78);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
Consumer end of the stopwatch time interface. Takes the running time and the recorded (lap) time as packed BCD, selects one per view mode, and scan-multiplexes it onto a 4-digit common-anode 7-segment display. Sits between the stopwatch core and the board pins. Owns a view-select button and a timed "show lap" hold after each record event.

Parameters:
REFRESH_DIV, 50000, Clk cycles each digit stays lit (min 2).
HOLD_FRAMES, 200, full 4-digit scan frames the lap is shown after a record event (min 1).

Ports:
Clk  input  1  system clock.
Rst  input  1  asynchronous, active-low reset.
iCurTime  input  16  running time, BCD [15:12] sec tens, [11:8] sec ones, [7:4] centi tens, [3:0] centi ones.
iRecTime  input  16  recorded lap time, same format.
iRecValid  input  1  one-cycle high pulse when iRecTime takes a new value.
fView  input  1  view button, active-low, asynchronous to Clk.
oSeg  output  7  segments {g,f,e,d,c,b,a}, active-low.
oDp  output  1  decimal point, active-low.
oDigit  output  4  digit enables, one-hot active-low, bit 0 = rightmost digit.
oMode  output  2  0 LIVE, 1 REC_HOLD, 2 REC_VIEW.

Behaviour:
- Reset (Rst low, async): oSeg 7'h7F, oDp 1, oDigit 4'hF, oMode LIVE, scan counter 0, digit index 0, frame register 16'h0000, hold counter 0, fView sync flops 1.
- fView: 2-FF synchronizer, then falling-edge detect on the synced value. This gives a 1-cycle view_evt 3 cycles after the pin falls. No debounce; the button conditioner upstream owns that.
- Scan: the counter counts 0..REFRESH_DIV-1. On wrap, the digit index increments mod 4. frame_end = wrap while the digit index is 3.
- Frame latch: the frame register loads the source selected by the current mode at frame_end, and in the first cycle after reset release. Digits never tear mid-frame.
- Source: LIVE uses iCurTime. REC_HOLD and REC_VIEW use iRecTime.
- FSM, evaluated every cycle:
  LIVE: view_evt goes to REC_VIEW. Otherwise iRecValid goes to REC_HOLD and loads the hold counter with HOLD_FRAMES.
  REC_HOLD: view_evt goes to REC_VIEW. Otherwise iRecValid reloads HOLD_FRAMES. Otherwise the hold counter decrements on each frame_end; at frame_end with count 1 it goes to LIVE.
  REC_VIEW: view_evt goes to LIVE. iRecValid is ignored; the new lap appears at the next frame_end.
  If view_evt and iRecValid occur in the same cycle, view_evt wins.
- Mode change takes effect on the source at the next frame_end only.
- Digit decode (combinational from digit index and frame nibble, then registered; outputs lag the index by 1 cycle):
  - 0-9 use standard active-low patterns (0 → 7'h40, 1 → 7'h79, 8 → 7'h00).
  - Nibble >9 shows a dash, 7'h3F.
  - Digit 3 blanks (7'h7F) when its nibble is 0 (leading-zero blanking, digit 3 only).
  - oDp is 0 on digit 2 only.
  - oDigit = ~(4'b0001 << index).
- Reset mid-frame: all outputs return to reset values immediately, without waiting for a Clk edge.

Decomposition:
- Shared package stopwatch_pkg holds:
  - mode encodings MODE_LIVE, MODE_REC_HOLD, MODE_REC_VIEW;
  - constants SEG_BLANK 7'h7F and SEG_DASH 7'h3F;
  - the BCD-to-segment lookup as a function.
- One natural sub-module: btn_edge_sync (2-FF sync plus falling-edge pulse). It is reused for the stopwatch core's fStart/fStop/fRecord.

Test Plan (REFRESH_DIV=4, HOLD_FRAMES=2, Clk period 20 ns):
1. Release reset with iCurTime=16'h0000 → oDigit cycles 1110,1101,1011,0111 every 4 clocks. Segments: digit0 7'h40, digit1 7'h40, digit2 7'h40 with oDp=0, digit3 7'h7F. oMode=0.
2. iCurTime=16'h1234 held, then changed to 16'h5678 mid-frame → the current frame still shows 1,2,3,4. The next frame shows 5,6,7,8 (digit3 7'h12). There is no mixed frame.
3. iRecTime=16'h0942, 1-cycle iRecValid in LIVE → oMode=1 next cycle. The frames after the next frame_end show 9.42 with digit3 blank. After 2 frame_ends oMode=0 and live time returns.
4. fView low for 10 clocks in LIVE → oMode=2 exactly 4 cycles after the pin falls. An iRecValid pulse is ignored (oMode stays 2). A second fView press → oMode=0.
5. fView falling edge and iRecValid arrive in the same synchronized cycle in LIVE → oMode=2, not 1. iRecTime=16'h0A00 → digit2 shows 7'h3F dash.
6. Assert Rst low mid-scan, between clock edges → oSeg=7'h7F, oDp=1, oDigit=4'hF, oMode=0 before the next Clk edge. After release, scanning restarts at digit 0.
